mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes several memory requesters onto the single core memory port.
- Requesters are instruction fetch, data access and a future DMA.
- Downstream it drives one memory-side interface with a ready/valid handshake, so it supports wait-state memories.
- Grants use round-robin fairness with one outstanding transaction at a time.

Parameters:
- DATA_W, 32, data bus width in bits.
- ADDR_W, 32, address width in bits.
- NCH, 2, number of requester channels (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- ch_req  in  NCH  per-channel request; held stable until ch_gnt.
- ch_we  in  NCH  per-channel write enable; 0 = read.
- ch_addr  in  NCH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_wd  in  NCH*DATA_W  packed write data.
- ch_gnt  out  NCH  one-hot accept pulse; request consumed this cycle.
- ch_rvalid  out  NCH  one-hot read-data-valid pulse.
- ch_rd  out  DATA_W  read data, shared; qualified by ch_rvalid.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request when mem_req & mem_ready.
- mem_rvalid  in  1  read data valid; arbitrary latency ≥1 cycle after accept.
- mem_rd  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, owner=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wd=0.
  - ch_rvalid=0, ch_rd=0; ch_gnt=0 (it is combinational).
- FSM states IDLE, ISSUE, WAIT_R.
- IDLE:
  - If any ch_req: pick the winner by round-robin, searching rr_ptr, rr_ptr+1, … with wrap modulo NCH.
  - Register owner, mem_addr, mem_we, mem_wd from the winner; set mem_req=1; go to ISSUE.
  - No request: stay in IDLE, mem_req=0.
- ISSUE:
  - mem_req held at 1 with stable outputs until mem_ready.
  - On mem_req & mem_ready: ch_gnt[owner]=1 combinationally in that cycle; mem_req←0; rr_ptr←(owner+1) mod NCH (wraps to 0 from NCH-1).
  - Then mem_we=1 → IDLE (write complete at accept; no rvalid); mem_we=0 → WAIT_R.
- WAIT_R:
  - On mem_rvalid: ch_rd←mem_rd, ch_rvalid[owner]←1 for exactly one cycle (registered, 1 cycle after mem_rvalid); go to IDLE.
- ch_gnt is asserted only in ISSUE & mem_ready; never more than one bit.
- ch_rvalid is registered, one-hot, one-cycle pulse; cleared the cycle after.
- mem_rvalid outside WAIT_R is ignored (spurious/late data dropped).
- Minimum occupancy:
  - Write: 2 cycles (IDLE→ISSUE with mem_ready=1).
  - Read: 3 cycles + memory latency.
- Channel sampling:
  - Requests are sampled only in IDLE; a request raised during ISSUE/WAIT_R waits.
  - A channel dropping ch_req before gnt is a protocol violation; the latched transaction still completes.
- Simultaneous events: mem_rvalid in the same cycle as new ch_req → data returned; new arbitration starts in the following IDLE cycle.
- NCH=1: rr_ptr is constantly 0; behaviour is a plain registered pass-through with handshake.
- Reset mid-operation: the outstanding transaction is abandoned, no gnt/rvalid is produced for it, and arbitration restarts at channel 0.

Decomposition:
- Shared package ktc32_pkg gets:
  - enum arb_state_t {IDLE, ISSUE, WAIT_R};
  - localparam XLEN=32, used as the default for DATA_W/ADDR_W.
- One natural sub-module: rr_pick, combinational.
  - Inputs: req[NCH], ptr.
  - Outputs: any, idx.
  - Purely the wrap-around priority search; reusable for later interrupt/DMA arbitration.

Test Plan:
- Single write: ch0 req, we=1, addr=0x100, wd=0xDEADBEEF, mem_ready=1 → mem_req high 1 cycle with those values; ch_gnt=01 same cycle; no ch_rvalid.
- Read with 3 wait states: ch1 read addr=0x40; mem_ready low 3 cycles then high; mem_rvalid 2 cycles later with 0x12345678 → ch_gnt=10 on accept; ch_rvalid=10 and ch_rd=0x12345678 one cycle after mem_rvalid.
- Fairness: NCH=3, all three channels request reads continuously, memory 1-cycle latency → grant order 0,1,2,0,1,2; rr_ptr wraps 2→0.
- Contention after wrap: rr_ptr=1; ch0 and ch1 request → ch1 wins first, then ch0.
- Spurious rvalid: mem_rvalid pulsed in IDLE with mem_rd=0xFFFF0000 → no ch_rvalid; ch_rd unchanged.
- Async reset during WAIT_R: reset low mid-cycle → all outputs 0 immediately. After release, a late mem_rvalid is ignored; the next ch1-only request is granted normally with rr_ptr=0 search.

Source files
------------

// File: rtl/ktc32_pkg.sv
// Shared definitions for the ktc32 core slice: arbiter FSM encoding,
// default bus width and index-width helper.
package ktc32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R
    } arb_state_t;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Wrap-around priority search: first asserted request at ptr, ptr+1, ...
// modulo NCH. Purely combinational.
module rr_pick
    import ktc32_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           any,
    output logic [IW-1:0]  idx
);

    localparam int unsigned N = NCH;

    int unsigned    cand;
    logic [NCH-1:0] shifted;

    // Walk from the farthest offset down so the closest match to ptr wins.
    always_comb begin
        any     = |req;
        idx     = '0;
        cand    = 0;
        shifted = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand    = (32'(ptr) + (N - 1 - k)) % N;
            shifted = req >> cand;
            if (shifted[0]) begin
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel arbiter onto a single ready/valid memory port,
// one outstanding transaction at a time.
module mem_port_arbiter
    import ktc32_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = XLEN,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*DATA_W-1:0] ch_wd,
    output logic [NCH-1:0]        ch_gnt,
    output logic [NCH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]     ch_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam int IW = idx_w(NCH);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     ptr_after;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              accept;
    logic              rdata_take;
    logic [ADDR_W-1:0] addr_a [NCH];
    logic [DATA_W-1:0] wd_a   [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign addr_a[i] = ch_addr[i*ADDR_W +: ADDR_W];
        assign wd_a[i]   = ch_wd[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req (ch_req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   if (mem_ready) state_nxt = mem_we ? IDLE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_req is high exactly while the latched transaction awaits acceptance.
    always_comb begin
        mem_req    = (state == ISSUE);
        accept     = mem_req & mem_ready;
        rdata_take = (state == WAIT_R) & mem_rvalid;
        ch_gnt     = accept ? (NCH'(1) << owner) : '0;
    end

    assign ptr_after = (owner == IW'(NCH - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= '0;
            rr_ptr   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                owner    <= pick_idx;
                mem_we   <= ch_we[pick_idx];
                mem_addr <= addr_a[pick_idx];
                mem_wd   <= wd_a[pick_idx];
            end
            if (accept) begin
                rr_ptr <= ptr_after;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_rvalid <= '0;
            ch_rd     <= '0;
        end else begin
            ch_rvalid <= rdata_take ? (NCH'(1) << owner) : '0;
            if (rdata_take) begin
                ch_rd <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NCH=3) with a transaction-level
// reference model checked on every falling edge.
module tb_mem_port_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   ch_req = '0;
    logic [N-1:0]   ch_we = '0;
    logic [N*W-1:0] ch_addr = '0;
    logic [N*W-1:0] ch_wd = '0;
    logic [N-1:0]   ch_gnt;
    logic [N-1:0]   ch_rvalid;
    logic [W-1:0]   ch_rd;
    logic           mem_req;
    logic           mem_we;
    logic [W-1:0]   mem_addr;
    logic [W-1:0]   mem_wd;
    logic           mem_ready = 1'b1;
    logic           mem_rvalid = 1'b0;
    logic [W-1:0]   mem_rd = '0;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;
    bit auto_mem = 0;
    bit auto_drop = 0;
    int rcount = 0;
    int glog[$];

    mem_port_arbiter #(
        .DATA_W (W),
        .ADDR_W (W),
        .NCH    (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_req     (ch_req),
        .ch_we      (ch_we),
        .ch_addr    (ch_addr),
        .ch_wd      (ch_wd),
        .ch_gnt     (ch_gnt),
        .ch_rvalid  (ch_rvalid),
        .ch_rd      (ch_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = free, 1 = request offered to memory, 2 = awaiting read data.
    int         m_phase = 0;
    int         m_owner = 0;
    int         m_ptr = 0;
    logic       m_we = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
    logic [N-1:0] m_rvalid = 0;

    function automatic int winner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase  <= 0;
            m_owner  <= 0;
            m_ptr    <= 0;
            m_we     <= 0;
            m_addr   <= 0;
            m_wd     <= 0;
            m_rd     <= 0;
            m_rvalid <= 0;
        end else begin
            m_rvalid <= 0;
            case (m_phase)
                0: if (ch_req != 0) begin
                    m_owner <= winner(ch_req, m_ptr);
                    m_we    <= ch_we[winner(ch_req, m_ptr)];
                    m_addr  <= ch_addr[winner(ch_req, m_ptr)*W +: W];
                    m_wd    <= ch_wd[winner(ch_req, m_ptr)*W +: W];
                    m_phase <= 1;
                end
                1: if (mem_ready) begin
                    m_ptr   <= (m_owner + 1) % N;
                    m_phase <= m_we ? 0 : 2;
                end
                2: if (mem_rvalid) begin
                    m_rvalid <= N'(1 << m_owner);
                    m_rd     <= mem_rd;
                    m_phase  <= 0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   32'(mem_req),   32'(m_phase == 1));
            chk("mem_we",    32'(mem_we),    32'(m_we));
            chk("mem_addr",  mem_addr,       m_addr);
            chk("mem_wd",    mem_wd,         m_wd);
            chk("ch_gnt",    32'(ch_gnt),    (m_phase == 1 && mem_ready) ? 32'(1 << m_owner) : 32'd0);
            chk("ch_rvalid", 32'(ch_rvalid), 32'(m_rvalid));
            chk("ch_rd",     ch_rd,          m_rd);
        end
    end

    // One cycle: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        logic         acc;
        logic [N-1:0] drop;
        drop = '0;
        @(negedge clk);
        acc = mem_req && mem_ready && !mem_we;
        for (int i = 0; i < N; i++) begin
            if (ch_gnt[i]) begin
                glog.push_back(i);
                if (auto_drop) drop[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ch_req = ch_req & ~drop;
        if (auto_mem) begin
            mem_rvalid = acc;
            mem_rd = 32'hA500_0000 + 32'(rcount);
            if (acc) rcount++;
        end
    endtask

    initial begin : stim
        int exp_fair[6];
        exp_fair = '{0, 1, 2, 0, 1, 2};
        #1 reset = 1'b0;
        chk_en = 1;
        @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ch_gnt", 32'(ch_gnt), 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;
        step();

        // Fairness: all three read continuously, 1-cycle memory latency.
        auto_mem = 1;
        mem_ready = 1;
        for (int i = 0; i < N; i++) ch_addr[i*W +: W] = 32'h1000 + 32'(i * 4);
        ch_req = 3'b111;
        for (int t = 0; t < 200 && glog.size() < 6; t++) step();
        chk("fair_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", glog[i], exp_fair[i]);
        ch_req = '0;
        repeat (3) step();

        // Single write on ch0, memory ready immediately.
        auto_mem = 0;
        mem_rvalid = 0;
        ch_we = 3'b001;
        ch_addr[0 +: W] = 32'h100;
        ch_wd[0 +: W] = 32'hDEADBEEF;
        ch_req = 3'b001;
        step();
        @(negedge clk);
        chk("wr_mem_req", 32'(mem_req), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_addr", mem_addr, 32'h100);
        chk("wr_wd", mem_wd, 32'hDEADBEEF);
        chk("wr_gnt", 32'(ch_gnt), 32'b001);
        @(posedge clk);
        #1;
        ch_req = '0;
        ch_we = '0;
        @(negedge clk);
        chk("wr_req_drop", 32'(mem_req), 0);
        chk("wr_no_rvalid", 32'(ch_rvalid), 0);
        @(posedge clk);
        #1;

        // Contention with rr_ptr=1: ch1 then ch0.
        glog.delete();
        auto_mem = 1;
        auto_drop = 1;
        ch_req = 3'b011;
        for (int t = 0; t < 200 && glog.size() < 2; t++) step();
        chk("cont_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("cont_first", glog[0], 1);
            chk("cont_second", glog[1], 0);
        end
        repeat (3) step();
        auto_mem = 0;
        auto_drop = 0;
        mem_rvalid = 0;

        // Read on ch1 with three wait states.
        ch_addr[1*W +: W] = 32'h40;
        ch_req = 3'b010;
        mem_ready = 0;
        step();
        repeat (3) step();
        mem_ready = 1;
        @(negedge clk);
        chk("rd_gnt", 32'(ch_gnt), 32'b010);
        chk("rd_addr", mem_addr, 32'h40);
        @(posedge clk);
        #1;
        ch_req = '0;
        step();
        mem_rvalid = 1;
        mem_rd = 32'h12345678;
        step();
        mem_rvalid = 0;
        mem_rd = '0;
        @(negedge clk);
        chk("rd_rvalid", 32'(ch_rvalid), 32'b010);
        chk("rd_data", ch_rd, 32'h12345678);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_rvalid_clr", 32'(ch_rvalid), 0);
        @(posedge clk);
        #1;

        // Spurious rvalid while idle.
        mem_rvalid = 1;
        mem_rd = 32'hFFFF0000;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        chk("spur_rvalid", 32'(ch_rvalid), 0);
        chk("spur_rd", ch_rd, 32'h12345678);
        @(posedge clk);
        #1;

        // Async reset while waiting for read data.
        ch_addr[2*W +: W] = 32'h80;
        ch_req = 3'b100;
        step();
        step();
        ch_req = '0;
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_gnt", 32'(ch_gnt), 0);
        chk("arst_rvalid", 32'(ch_rvalid), 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_wd", mem_wd, 0);
        chk("arst_rd", ch_rd, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_rvalid = 1;
        mem_rd = 32'h0BAD0BAD;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid", 32'(ch_rvalid), 0);
        chk("late_rd", ch_rd, 0);
        @(posedge clk);
        #1;
        ch_addr[1*W +: W] = 32'h44;
        ch_req = 3'b010;
        step();
        @(negedge clk);
        chk("post_gnt", 32'(ch_gnt), 32'b010);
        chk("post_addr", mem_addr, 32'h44);
        @(posedge clk);
        #1;
        ch_req = '0;
        repeat (2) step();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
